// File: rtl/colour_shuffler_if.sv
// colour_shuffler_if: button/frame inputs and palette/status outputs of the colour shuffler.
//   shuffle_req    raw asynchronous button level, a rising edge requests a shuffle
//   frame_start    one-cycle pulse at the display frame boundary
//   colourLocation four 3-bit RGB slot colours, slot0..slot3
//   busy           high while a shuffle is in progress
//   shuffle_count  number of committed shuffles, wraps 255->0
interface colour_shuffler_if;
    logic                 shuffle_req;
    logic                 frame_start;
    logic [0:3][0:2]      colourLocation;
    logic                 busy;
    logic [7:0]           shuffle_count;
    modport master (output shuffle_req, frame_start, input colourLocation, busy, shuffle_count);
    modport slave  (input shuffle_req, frame_start, output colourLocation, busy, shuffle_count);
endinterface

// File: rtl/colour_shuffler.sv
// colour_shuffler: Fisher-Yates shuffle of a 4-slot RGB palette driven by a free-running LFSR.
//   CLOCK_50  sole clock, rising edge
//   reset     synchronous active-high reset
//   bus       colour_shuffler_if.slave (shuffle_req, frame_start in; colourLocation, busy, shuffle_count out)
// Optional macro COLOUR_SHUFFLER_DEBOUNCE_EN inserts a DEBOUNCE_CYCLES debouncer after the synchronizer.
module colour_shuffler #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input logic              CLOCK_50,
    input logic              reset,
    colour_shuffler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAW, COMMIT} state_t;
    localparam logic [15:0]     SEED    = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [0:3][0:2] PALETTE = {3'd4, 3'd2, 3'd1, 3'd6};
    state_t          state, state_n;
    logic [15:0]     lfsr;
    logic            sync1, sync2, level, level_q, press, take;
    logic [0:3][0:2] work, work_n, colour;
    logic [1:0]      idx, idx_n, j;
    logic [7:0]      count;
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1   <= bus.shuffle_req;
            sync2   <= sync1;
            level_q <= level;
        end
    end
`ifdef COLOUR_SHUFFLER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    logic [CW-1:0] db_cnt;
    // Any cycle where the synchronized level agrees with the debounced one restarts the count.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level  <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end
`else
    logic [31:0] unused_debounce;
    assign unused_debounce = DEBOUNCE_CYCLES;
    assign level = sync2;
`endif
    assign press = level & ~level_q;
    assign j     = lfsr[1:0];
    // A draw larger than the current index is rejected and retried with the next LFSR value.
    assign take  = (state == DRAW) && (j <= idx);
    always_comb begin
        state_n = state;
        work_n  = work;
        idx_n   = idx;
        case (state)
            IDLE: if (press) begin
                work_n  = colour;
                idx_n   = 2'd3;
                state_n = DRAW;
            end
            DRAW: if (take) begin
                work_n[idx] = work[j];
                work_n[j]   = work[idx];
                idx_n       = idx - 2'd1;
                state_n     = (idx == 2'd1) ? COMMIT : DRAW;
            end
            COMMIT: state_n = bus.frame_start ? IDLE : COMMIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= IDLE;
            lfsr   <= SEED;
            work   <= PALETTE;
            colour <= PALETTE;
            idx    <= 2'd0;
            count  <= 8'd0;
        end else begin
            state <= state_n;
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            work  <= work_n;
            idx   <= idx_n;
            if (state == COMMIT && bus.frame_start) begin
                colour <= work;
                count  <= count + 8'd1;
            end
        end
    end
    assign bus.colourLocation = colour;
    assign bus.busy           = (state != IDLE);
    assign bus.shuffle_count  = count;
endmodule

// File: tb/tb_colour_shuffler.sv
// tb_colour_shuffler: directed + randomized-gap checks of colour_shuffler against a Fisher-Yates reference model.
module tb_colour_shuffler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    colour_shuffler_if bus ();
    colour_shuffler #(.DEBOUNCE_CYCLES(16)) dut (.CLOCK_50(clk), .reset(reset), .bus(bus));
    // Reference LFSR: feedback is the parity of taps 15,13,12,10.
    logic [15:0] m_lfsr;
    always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    logic [2:0] m_col [4];
    logic [7:0] m_cnt;
    function automatic logic [11:0] pack_model();
        return {m_col[0], m_col[1], m_col[2], m_col[3]};
    endfunction
    function automatic logic [7:0] colour_set(input logic [11:0] v);
        logic [7:0] s = 8'd0;
        for (int k = 0; k < 4; k++) s[v[k*3 +: 3]] = 1'b1;
        return s;
    endfunction
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_col[0] = 3'd4; m_col[1] = 3'd2; m_col[2] = 3'd1; m_col[3] = 3'd6;
        m_cnt = 8'd0;
    endtask
    task automatic watch_idle(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen |= bus.busy;
        end
        check(tag, seen, 1'b0);
        check({tag, "_count"}, bus.shuffle_count, m_cnt);
    endtask
    // One full shuffle: press, follow the draws with the model, commit, compare.
    task automatic do_shuffle(input bit second, input bit hold, input int max_lat);
        int lat = 0;
        int mi = 3;
        int guard = 0;
        int jj;
        logic [2:0] w [4];
        logic [2:0] t;
        repeat (24) @(negedge clk);
        check("idle_before_press", bus.busy, 1'b0);
        if (hold) bus.frame_start = 1'b0;
        bus.shuffle_req = 1'b1;
        while (!bus.busy && lat < max_lat) begin
            @(negedge clk);
            lat++;
        end
        check("busy_rise", bus.busy, 1'b1);
`ifndef COLOUR_SHUFFLER_DEBOUNCE_EN
        check("press_latency", lat, 3);
`endif
        bus.shuffle_req = 1'b0;
        for (int k = 0; k < 4; k++) w[k] = m_col[k];
        while (mi >= 1 && guard < 100) begin
            jj = int'(m_lfsr[1:0]);
            if (jj <= mi) begin
                t = w[mi]; w[mi] = w[jj]; w[jj] = t;
                mi--;
            end
            @(negedge clk);
            guard++;
            if (second) bus.shuffle_req = (guard == 1);
            check("busy_during_draw", bus.busy, 1'b1);
            check("colour_frozen_draw", bus.colourLocation, pack_model());
        end
        check("draw_bound", guard < 100, 1'b1);
        if (hold) begin
            repeat (1000) begin
                @(negedge clk);
                check("hold_busy", bus.busy, 1'b1);
                check("hold_colour", bus.colourLocation, pack_model());
            end
            bus.frame_start = 1'b1;
            @(negedge clk);
            bus.frame_start = 1'b0;
        end else begin
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) m_col[k] = w[k];
        m_cnt++;
        check("commit_colour", bus.colourLocation, pack_model());
        check("commit_busy", bus.busy, 1'b0);
        check("commit_count", bus.shuffle_count, m_cnt);
        check("permutation", colour_set(bus.colourLocation), 8'h56);
        bus.frame_start = 1'b1;
    endtask
    initial begin
        int lat;
        bus.shuffle_req = 1'b0;
        bus.frame_start = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_colour", bus.colourLocation, pack_model());
        check("reset_busy", bus.busy, 1'b0);
        check("reset_count", bus.shuffle_count, 8'd0);
        check("reset_lfsr", dut.lfsr, 16'hACE1);
        reset = 1'b0;
`ifdef COLOUR_SHUFFLER_DEBOUNCE_EN
        repeat (24) @(negedge clk);
        bus.shuffle_req = 1'b1;
        repeat (10) @(negedge clk);
        bus.shuffle_req = 1'b0;
        watch_idle("glitch_no_shuffle", 60);
        do_shuffle(1'b0, 1'b0, 40);
        watch_idle("debounced_single", 60);
`endif
        do_shuffle(1'b0, 1'b0, 40);
`ifndef COLOUR_SHUFFLER_DEBOUNCE_EN
        do_shuffle(1'b1, 1'b0, 40);
        watch_idle("discard_while_busy", 30);
`endif
        do_shuffle(1'b0, 1'b1, 40);
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            do_shuffle(1'b0, 1'b0, 40);
        end
        repeat (24) @(negedge clk);
        bus.shuffle_req = 1'b1;
        lat = 0;
        while (!bus.busy && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("middraw_busy", bus.busy, 1'b1);
        bus.shuffle_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check("middraw_reset_colour", bus.colourLocation, pack_model());
        check("middraw_reset_busy", bus.busy, 1'b0);
        check("middraw_reset_count", bus.shuffle_count, 8'd0);
        check("middraw_reset_lfsr", dut.lfsr, 16'hACE1);
        reset = 1'b0;
        for (int n = 0; n < 256; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_shuffle(1'b0, 1'b0, 40);
        end
        check("count_wrap", bus.shuffle_count, m_cnt);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
